// File: rtl/fpnew_rounding_arbiter.sv
// Round-robin arbiter sharing one rounding datapath between NumReq requesters.
// A single registered output stage with valid/ready returns result, requester index and tag.
module fpnew_rounding_arbiter #(
  parameter  int unsigned NumReq   = 4,
  parameter  int unsigned AbsWidth = 31,
  parameter  int unsigned TagWidth = 3,
  localparam int unsigned IdW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic [NumReq-1:0]               in_valid_i,
  output logic [NumReq-1:0]               in_ready_o,
  input  logic [NumReq-1:0][AbsWidth-1:0] abs_value_i,
  input  logic [NumReq-1:0]               sign_i,
  input  logic [NumReq-1:0][1:0]          round_sticky_bits_i,
  input  logic [NumReq-1:0][2:0]          rnd_mode_i,
  input  logic [NumReq-1:0]               effective_subtraction_i,
  input  logic [NumReq-1:0][TagWidth-1:0] tag_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [AbsWidth-1:0]             abs_rounded_o,
  output logic                            sign_o,
  output logic                            exact_zero_o,
  output logic                            inexact_o,
  output logic [IdW-1:0]                  req_id_o,
  output logic [TagWidth-1:0]             tag_o,
  output logic                            busy_o
);

  localparam int unsigned SumW   = IdW + 1;
  localparam logic [2:0]  RM_RNE = 3'b000;
  localparam logic [2:0]  RM_RTZ = 3'b001;
  localparam logic [2:0]  RM_RDN = 3'b010;
  localparam logic [2:0]  RM_RUP = 3'b011;
  localparam logic [2:0]  RM_RMM = 3'b100;

  function automatic logic round_up_f(input logic [2:0] mode, input logic [1:0] rs,
                                      input logic lsb, input logic sgn);
    logic up;
    case (mode)
      RM_RNE:  up = rs[1] & (rs[0] | lsb);
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = (|rs) & sgn;
      RM_RUP:  up = (|rs) & ~sgn;
      RM_RMM:  up = rs[1];
      default: up = 1'b0;
    endcase
    return up;
  endfunction

  logic                r_out_valid;
  logic [IdW-1:0]      r_ptr;
  logic [AbsWidth-1:0] r_abs_rounded;
  logic                r_sign;
  logic                r_exact_zero;
  logic                r_inexact;
  logic [IdW-1:0]      r_req_id;
  logic [TagWidth-1:0] r_tag;

  logic                w_grant_valid;
  logic [IdW-1:0]      w_grant_idx;
  logic                w_stage_ready;
  logic                w_transfer;
  logic [AbsWidth-1:0] w_sel_abs;
  logic [1:0]          w_sel_rs;
  logic                w_sel_sign;
  logic                w_sel_eff_sub;
  logic [2:0]          w_sel_mode;
  logic                w_round_up;
  logic [AbsWidth-1:0] w_abs_rounded;
  logic                w_exact_zero;
  logic                w_sign;
  logic [IdW-1:0]      w_ptr_next;

  // Round-robin search: first valid requester at or after the priority pointer
  always_comb begin
    logic [SumW-1:0] v_sum;
    logic [IdW-1:0]  v_idx;
    v_sum         = '0;
    v_idx         = '0;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      v_sum         = {1'b0, r_ptr} + SumW'(k);
      v_sum         = (v_sum >= SumW'(NumReq)) ? (v_sum - SumW'(NumReq)) : v_sum;
      v_idx         = v_sum[IdW-1:0];
      w_grant_idx   = (!w_grant_valid && in_valid_i[v_idx]) ? v_idx : w_grant_idx;
      w_grant_valid = w_grant_valid | in_valid_i[v_idx];
    end
  end

  assign w_stage_ready = ~r_out_valid | out_ready_i;
  assign w_transfer    = w_grant_valid & w_stage_ready & ~flush_i & ~rst_i;
  assign in_ready_o    = w_transfer ? (NumReq'(1) << w_grant_idx) : '0;

  assign w_sel_abs     = abs_value_i[w_grant_idx];
  assign w_sel_rs      = round_sticky_bits_i[w_grant_idx];
  assign w_sel_sign    = sign_i[w_grant_idx];
  assign w_sel_eff_sub = effective_subtraction_i[w_grant_idx];
  // Unsupported encodings truncate so nothing undefined reaches the datapath
  assign w_sel_mode    = (rnd_mode_i[w_grant_idx] > RM_RMM) ? RM_RTZ : rnd_mode_i[w_grant_idx];

  assign w_round_up    = round_up_f(w_sel_mode, w_sel_rs, w_sel_abs[0], w_sel_sign);
  assign w_abs_rounded = w_sel_abs + AbsWidth'(w_round_up);
  assign w_exact_zero  = (w_sel_abs == '0) & (w_sel_rs == 2'b00);
  assign w_sign        = (w_exact_zero & w_sel_eff_sub) ? (w_sel_mode == RM_RDN) : w_sel_sign;
  assign w_ptr_next    = (w_grant_idx == IdW'(NumReq - 1)) ? '0 : (w_grant_idx + IdW'(1));

  // Output-stage occupancy and priority pointer; flush wins over drain and load
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_transfer) begin
      r_out_valid <= 1'b1;
      r_ptr       <= w_ptr_next;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Result payload captured on every accepted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_abs_rounded <= '0;
      r_sign        <= 1'b0;
      r_exact_zero  <= 1'b0;
      r_inexact     <= 1'b0;
      r_req_id      <= '0;
      r_tag         <= '0;
    end else if (w_transfer) begin
      r_abs_rounded <= w_abs_rounded;
      r_sign        <= w_sign;
      r_exact_zero  <= w_exact_zero;
      r_inexact     <= |w_sel_rs;
      r_req_id      <= w_grant_idx;
      r_tag         <= tag_i[w_grant_idx];
    end
  end

  assign out_valid_o   = r_out_valid;
  assign busy_o        = r_out_valid;
  assign abs_rounded_o = r_abs_rounded;
  assign sign_o        = r_sign;
  assign exact_zero_o  = r_exact_zero;
  assign inexact_o     = r_inexact;
  assign req_id_o      = r_req_id;
  assign tag_o         = r_tag;

endmodule

// File: tb/tb_fpnew_rounding_arbiter.sv
// Bench for fpnew_rounding_arbiter: rounding vector table, hand-written arbitration
// and stall/flush/reset sequences, then random traffic against a reference model.
module tb_fpnew_rounding_arbiter;
  localparam int NR = 4;
  localparam int AW = 31;
  localparam int TW = 3;
  localparam int IW = 2;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

  logic clk, rst, flush, out_ready;
  logic [NR-1:0] in_valid, in_ready, sign, eff_sub;
  logic [NR-1:0][AW-1:0] abs_value;
  logic [NR-1:0][1:0] rs;
  logic [NR-1:0][2:0] mode;
  logic [NR-1:0][TW-1:0] tag;
  logic out_valid, sign_o, exact_zero, inexact, busy;
  logic [AW-1:0] abs_rounded;
  logic [IW-1:0] req_id;
  logic [TW-1:0] tag_o;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] abs; logic [1:0] rs; logic [2:0] mode; logic sgn; logic es;
    logic [AW-1:0] x_abs; logic x_sign; logic x_zero; logic x_inx;
  } vec_t;
  typedef struct { logic [AW-1:0] abs; logic sgn; logic zero; logic inx; } res_t;

  fpnew_rounding_arbiter #(.NumReq(NR), .AbsWidth(AW), .TagWidth(TW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .abs_value_i(abs_value), .sign_i(sign), .round_sticky_bits_i(rs),
    .rnd_mode_i(mode), .effective_subtraction_i(eff_sub), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .abs_rounded_o(abs_rounded), .sign_o(sign_o), .exact_zero_o(exact_zero),
    .inexact_o(inexact), .req_id_o(req_id), .tag_o(tag_o), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [1:0] r,
                         input logic [2:0] m, input logic s, input logic es,
                         input logic [TW-1:0] t);
    abs_value[i] = a; rs[i] = r; mode[i] = m; sign[i] = s; eff_sub[i] = es; tag[i] = t;
  endtask

  // Rounding decided from the fraction below the LSB: 0 exact, 1 below half, 2 half, 3 above half
  function automatic res_t ref_round(input logic [AW-1:0] a, input logic [1:0] rsb,
                                     input logic [2:0] m, input logic s, input logic es);
    int frac; bit up; res_t r; longint sum;
    frac = int'(rsb);
    case (m)
      RNE:     up = (frac == 3) || (frac == 2 && (a % 2) == 1);
      RDN:     up = (frac != 0) && s;
      RUP:     up = (frac != 0) && !s;
      RMM:     up = (frac >= 2);
      default: up = 1'b0;
    endcase
    sum    = longint'(a) + longint'(up);
    r.abs  = AW'(sum % 64'd2147483648);
    r.zero = (a == 0) && (frac == 0);
    r.sgn  = (r.zero && es) ? (m == RDN) : s;
    r.inx  = (frac != 0);
    return r;
  endfunction

  vec_t tbl[16];
  bit rv[NR];
  int m_ptr, m_id, g;
  bit m_valid, xfer;
  res_t m_res;
  logic [TW-1:0] m_tag;
  logic [NR-1:0] x_ready;

  initial begin
    tbl[0]  = '{31'h5, 2'b10, RNE, 1'b0, 1'b0, 31'h6, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{31'h4, 2'b10, RNE, 1'b0, 1'b0, 31'h4, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{31'h4, 2'b11, RNE, 1'b0, 1'b0, 31'h5, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{31'h4, 2'b01, RNE, 1'b0, 1'b0, 31'h4, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{31'h0, 2'b00, RDN, 1'b0, 1'b1, 31'h0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{31'h0, 2'b00, RNE, 1'b0, 1'b1, 31'h0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{31'h7, 2'b11, 3'b101, 1'b0, 1'b0, 31'h7, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{31'h7, 2'b01, RUP, 1'b0, 1'b0, 31'h8, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{31'h7, 2'b01, RUP, 1'b1, 1'b0, 31'h7, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{31'h7, 2'b01, RDN, 1'b1, 1'b0, 31'h8, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{31'h9, 2'b10, RMM, 1'b0, 1'b0, 31'hA, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{31'h9, 2'b01, RMM, 1'b0, 1'b0, 31'h9, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{31'h7FFFFFFF, 2'b11, RNE, 1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{31'h3, 2'b10, 3'b111, 1'b0, 1'b0, 31'h3, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{31'h0, 2'b01, RNE, 1'b1, 1'b1, 31'h0, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{31'h0, 2'b00, RNE, 1'b1, 1'b0, 31'h0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = '1;
    abs_value = '0; rs = '0; mode = '0; sign = '0; eff_sub = '0; tag = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_abs", 64'(abs_rounded), 64'd0);
    chk("rst_req_id", 64'(req_id), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = '0;
    rst = 1'b0;

    for (int n = 0; n < 16; n++) begin
      int idx;
      idx = n % NR;
      in_valid = '0;
      set_req(idx, tbl[n].abs, tbl[n].rs, tbl[n].mode, tbl[n].sgn, tbl[n].es, TW'((n + 3) % 8));
      in_valid[idx] = 1'b1;
      #1;
      chk($sformatf("tbl%0d_ready", n), 64'(in_ready), 64'(4'b0001 << idx));
      tick();
      chk($sformatf("tbl%0d_valid", n), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d_abs", n), 64'(abs_rounded), 64'(tbl[n].x_abs));
      chk($sformatf("tbl%0d_sign", n), 64'(sign_o), 64'(tbl[n].x_sign));
      chk($sformatf("tbl%0d_zero", n), 64'(exact_zero), 64'(tbl[n].x_zero));
      chk($sformatf("tbl%0d_inexact", n), 64'(inexact), 64'(tbl[n].x_inx));
      chk($sformatf("tbl%0d_req_id", n), 64'(req_id), 64'(idx));
      chk($sformatf("tbl%0d_tag", n), 64'(tag_o), 64'((n + 3) % 8));
    end

    // stall a result from req2 (pointer moves to 3), then reset mid-stall
    in_valid = 4'b0100;
    #1;
    chk("stall_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    in_valid = '0; out_ready = 1'b0;
    tick();
    chk("stall_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < NR; i++) set_req(i, AW'(16 * i + 1), 2'b00, RTZ, 1'b0, 1'b0, TW'(i + 4));
    in_valid = '1; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // round robin with every requester valid; pointer restarts at 0 after reset
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("rr%0d_ready", n), 64'(in_ready), 64'(4'b0001 << (n % NR)));
      tick();
      chk($sformatf("rr%0d_valid", n), 64'(out_valid), 64'd1);
      chk($sformatf("rr%0d_req_id", n), 64'(req_id), 64'(n % NR));
      chk($sformatf("rr%0d_tag", n), 64'(tag_o), 64'((n % NR) + 4));
      #1;
    end

    // backpressure: result from req0 held while reqs 1 and 2 wait
    in_valid = 4'b0001;
    #1;
    chk("bp_ready0", 64'(in_ready), 64'(4'b0001));
    tick();
    in_valid = 4'b0110; out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_ready_hold", 64'(in_ready), 64'd0);
      tick();
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_id_hold", 64'(req_id), 64'd0);
      chk("bp_abs_hold", 64'(abs_rounded), 64'd1);
      chk("bp_tag_hold", 64'(tag_o), 64'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'(4'b0010));
    tick();
    chk("bp_release_id", 64'(req_id), 64'd1);
    in_valid = 4'b0100;
    #1;
    chk("bp_next_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    chk("bp_next_id", 64'(req_id), 64'd2);

    // flush with a pending result: nothing accepted, pointer stays at 3
    in_valid = 4'b1001; flush = 1'b1;
    #1;
    chk("flush_ready", 64'(in_ready), 64'd0);
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    #1;
    chk("post_flush_ready", 64'(in_ready), 64'(4'b1000));
    tick();
    chk("post_flush_id", 64'(req_id), 64'd3);
    chk("post_flush_valid", 64'(out_valid), 64'd1);

    // random traffic against the reference model
    in_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_tag = '0; m_res = '{'0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < NR; i++) rv[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd_abs", 64'(abs_rounded), 64'(m_res.abs));
        chk("rnd_sign", 64'(sign_o), 64'(m_res.sgn));
        chk("rnd_zero", 64'(exact_zero), 64'(m_res.zero));
        chk("rnd_inexact", 64'(inexact), 64'(m_res.inx));
        chk("rnd_req_id", 64'(req_id), 64'(m_id));
        chk("rnd_tag", 64'(tag_o), 64'(m_tag));
      end
      for (int i = 0; i < NR; i++) begin
        if (!rv[i] && $urandom_range(0, 99) < 45) begin
          rv[i] = 1'b1;
          case ($urandom_range(0, 3))
            0:       abs_value[i] = '0;
            1:       abs_value[i] = '1;
            default: abs_value[i] = AW'($urandom());
          endcase
          rs[i] = 2'($urandom_range(0, 3));
          mode[i] = 3'($urandom_range(0, 7));
          sign[i] = 1'($urandom_range(0, 1));
          eff_sub[i] = 1'($urandom_range(0, 1));
          tag[i] = TW'($urandom_range(0, 7));
        end
        in_valid[i] = rv[i];
      end
      out_ready = ($urandom_range(0, 99) < 70);
      flush = ($urandom_range(0, 99) < 6);
      #1;
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (g < 0 && rv[idx]) g = idx;
      end
      xfer = (!m_valid || out_ready) && (g >= 0) && !flush;
      x_ready = xfer ? (NR'(1) << g) : '0;
      chk("rnd_ready", 64'(in_ready), 64'(x_ready));
      if (flush) begin
        m_valid = 1'b0;
      end else if (xfer) begin
        m_valid = 1'b1;
        m_res = ref_round(abs_value[g], rs[g], mode[g], sign[g], eff_sub[g]);
        m_id = g;
        m_tag = tag[g];
        m_ptr = (g + 1) % NR;
        rv[g] = 1'b0;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      tick();
    end
    chk("rnd_final_valid", 64'(out_valid), 64'(m_valid));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
